chacha_arbiter: RTL and testbench

CHACHA_ARBITER -- requirements
Module: chacha_arbiter

---
 rtl/chacha_arbiter.sv | 150 +++++++++++++++
 tb/tb_chacha_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_arbiter.sv
// Two-channel round-robin front end for a single ChaCha core: grants one request,
// launches the core, waits for a fresh result and returns it. Optional core
// timeout watchdog is enabled by defining CHACHA_ARB_TIMEOUT_EN.
module chacha_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic            chacha_arb_clk,
   input  logic            chacha_arb_reset,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [511:0]    req_key,
   input  logic [127:0]    req_nonce,
   input  logic [127:0]    req_ctr,
   input  logic [1023:0]   req_data,
   output logic [1:0]      resp_valid,
   output logic [511:0]    resp_data,
   output logic            core_init,
   output logic [255:0]    core_key,
   output logic [63:0]     core_iv,
   output logic [63:0]     core_ctr,
   output logic [511:0]    core_data_in,
   input  logic [511:0]    core_data_out,
   input  logic            core_data_out_valid,
   output logic            busy,
   output logic            timeout_err,
   output logic [2:0]      state_dbg
);

   // Handshake: a requester holds req_valid until it sees its req_ready bit
   // for one cycle; resp_valid is a one-cycle pulse with no back-pressure.

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      WAIT_LOW  = 3'd2,
      WAIT_HIGH = 3'd3,
      RESP      = 3'd4
   } state_t;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t state, state_nxt;
   logic   grant;
   logic   last_grant;
   logic   sel;
   logic   timeout_fire;
   logic   waiting;

   assign waiting = (state == WAIT_LOW) || (state == WAIT_HIGH);

   // Contention goes to the channel that was not served last.
   assign sel = (req_valid == 2'b11) ? ~last_grant : req_valid[1];

`ifdef CHACHA_ARB_TIMEOUT_EN
   logic [31:0] wait_cnt;
   logic        timeout_hit;

   assign timeout_hit  = (wait_cnt == TIMEOUT_CYCLES - 32'd1);
   // A real result in the same cycle as expiry still wins.
   assign timeout_fire = waiting && timeout_hit &&
                         !((state == WAIT_HIGH) && core_data_out_valid);

   always_ff @(posedge chacha_arb_clk) begin
      if (chacha_arb_reset) begin
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == LAUNCH)
            wait_cnt <= '0;
         else if (waiting && !timeout_hit)
            wait_cnt <= wait_cnt + 32'd1;
         if (timeout_fire)
            timeout_err <= 1'b1;
      end
   end
`else
   assign timeout_fire = 1'b0;
   assign timeout_err  = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (|req_valid) state_nxt = LAUNCH;
         LAUNCH:    state_nxt = WAIT_LOW;
         WAIT_LOW: begin
            if (timeout_fire)              state_nxt = RESP;
            else if (!core_data_out_valid) state_nxt = WAIT_HIGH;
         end
         WAIT_HIGH: begin
            if (core_data_out_valid || timeout_fire) state_nxt = RESP;
         end
         RESP:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = 2'b00;
      resp_valid = 2'b00;
      core_init  = 1'b0;
      if (state == LAUNCH) begin
         core_init = 1'b1;
         req_ready = grant ? 2'b10 : 2'b01;
      end
      if (state == RESP)
         resp_valid = grant ? 2'b10 : 2'b01;
   end

   assign busy      = (state != IDLE);
   assign state_dbg = state;

   always_ff @(posedge chacha_arb_clk) begin
      if (chacha_arb_reset) begin
         state        <= IDLE;
         grant        <= 1'b0;
         last_grant   <= 1'b1;
         core_key     <= '0;
         core_iv      <= '0;
         core_ctr     <= '0;
         core_data_in <= '0;
         resp_data    <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  grant        <= sel;
                  core_key     <= sel ? req_key[511:256]   : req_key[255:0];
                  core_iv      <= sel ? req_nonce[127:64]  : req_nonce[63:0];
                  core_ctr     <= sel ? req_ctr[127:64]    : req_ctr[63:0];
                  core_data_in <= sel ? req_data[1023:512] : req_data[511:0];
               end
            end
            WAIT_LOW: begin
               if (timeout_fire) resp_data <= '0;
            end
            WAIT_HIGH: begin
               if (core_data_out_valid) resp_data <= core_data_out;
               else if (timeout_fire)   resp_data <= '0;
            end
            RESP: last_grant <= grant;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chacha_arbiter.sv
// Directed bench for chacha_arbiter; the core is modelled by driving
// core_data_out/core_data_out_valid on chosen cycles.
module tb_chacha_arbiter;

   logic            clk = 1'b0;
   logic            chacha_arb_reset;
   logic [1:0]      req_valid;
   logic [1:0]      req_ready;
   logic [511:0]    req_key;
   logic [127:0]    req_nonce;
   logic [127:0]    req_ctr;
   logic [1023:0]   req_data;
   logic [1:0]      resp_valid;
   logic [511:0]    resp_data;
   logic            core_init;
   logic [255:0]    core_key;
   logic [63:0]     core_iv;
   logic [63:0]     core_ctr;
   logic [511:0]    core_data_in;
   logic [511:0]    core_data_out;
   logic            core_data_out_valid;
   logic            busy;
   logic            timeout_err;
   logic [2:0]      state_dbg;

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [255:0] KEY0 = 256'h1;
   localparam logic [255:0] KEY1 = 256'hc1c1_0000_dead_beef_0123_4567_89ab_cdef;

   chacha_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .chacha_arb_clk      (clk),
      .chacha_arb_reset    (chacha_arb_reset),
      .req_valid           (req_valid),
      .req_ready           (req_ready),
      .req_key             (req_key),
      .req_nonce           (req_nonce),
      .req_ctr             (req_ctr),
      .req_data            (req_data),
      .resp_valid          (resp_valid),
      .resp_data           (resp_data),
      .core_init           (core_init),
      .core_key            (core_key),
      .core_iv             (core_iv),
      .core_ctr            (core_ctr),
      .core_data_in        (core_data_in),
      .core_data_out       (core_data_out),
      .core_data_out_valid (core_data_out_valid),
      .busy                (busy),
      .timeout_err         (timeout_err),
      .state_dbg           (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      chacha_arb_reset = 1'b1;
      tick();
      chacha_arb_reset = 1'b0;
   endtask

   // Runs one request from IDLE; the core answers 'delay' cycles after init.
   // Returns with the DUT in RESP (or after the cycle budget, resp_cyc = -1).
   task automatic do_op(input logic [1:0] rv, input int delay, input logic [511:0] val,
                        output logic [1:0] ready, output logic [255:0] key,
                        output int n_init, output int resp_cyc,
                        output logic [1:0] resp_v, output logic [511:0] resp_d,
                        output int overlap, output int unstable);
      req_valid = rv;
      tick();
      ready    = req_ready;
      key      = core_key;
      n_init   = int'(core_init);
      overlap  = (|resp_valid) ? 1 : 0;
      unstable = 0;
      resp_cyc = -1;
      resp_v   = 2'b00;
      resp_d   = '0;
      req_valid = 2'b00;
      for (int c = 1; c < 60; c++) begin
         if (c == delay + 1) begin
            core_data_out_valid = 1'b1;
            core_data_out       = val;
         end else if (c == delay + 2) begin
            core_data_out_valid = 1'b0;
         end
         tick();
         n_init += int'(core_init);
         if ((|req_ready && |resp_valid) || req_ready == 2'b11 || resp_valid == 2'b11)
            overlap++;
         if (core_key !== key) unstable++;
         if (resp_valid != 2'b00) begin
            resp_cyc = c + 1;
            resp_v   = resp_valid;
            resp_d   = resp_data;
            break;
         end
      end
      core_data_out_valid = 1'b0;
   endtask

   task automatic test_reset();
      chacha_arb_reset = 1'b1;
      tick();
      tick();
      n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready: got %0h want 0", req_ready); else n_pass++;
      n_checks++; if (resp_valid !== 2'b00) $display("FAIL reset_resp_valid: got %0h want 0", resp_valid); else n_pass++;
      n_checks++; if (core_init !== 1'b0) $display("FAIL reset_core_init: got %0b want 0", core_init); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
      n_checks++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %0b want 0", timeout_err); else n_pass++;
      n_checks++; if (core_key !== '0 || core_iv !== '0 || core_ctr !== '0 || core_data_in !== '0)
         $display("FAIL reset_operands: got key %h want 0", core_key); else n_pass++;
      n_checks++; if (resp_data !== '0) $display("FAIL reset_resp_data: got %h want 0", resp_data); else n_pass++;
      n_checks++; if (state_dbg !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_dbg); else n_pass++;
      chacha_arb_reset = 1'b0;
      tick();
   endtask

   task automatic test_single_ch0();
      logic [1:0]   rdy, rv;
      logic [255:0] key;
      logic [511:0] rd;
      logic [511:0] val;
      int           ni, rc, ov, us;
      val = {16{32'h5a5a_0001}};
      do_op(2'b01, 10, val, rdy, key, ni, rc, rv, rd, ov, us);
      n_checks++; if (rdy !== 2'b01) $display("FAIL single_req_ready: got %0h want 1", rdy); else n_pass++;
      n_checks++; if (key !== KEY0) $display("FAIL single_core_key: got %h want %h", key, KEY0); else n_pass++;
      n_checks++; if (core_iv !== 64'h0 || core_ctr !== 64'h0 || core_data_in !== '0)
         $display("FAIL single_operands: got iv %h ctr %h want 0", core_iv, core_ctr); else n_pass++;
      n_checks++; if (ni !== 1) $display("FAIL single_init_count: got %0d want 1", ni); else n_pass++;
      n_checks++; if (rc !== 12) $display("FAIL single_resp_cycle: got %0d want 12", rc); else n_pass++;
      n_checks++; if (rv !== 2'b01) $display("FAIL single_resp_valid: got %0h want 1", rv); else n_pass++;
      n_checks++; if (rd !== val) $display("FAIL single_resp_data: got %h want %h", rd, val); else n_pass++;
      n_checks++; if (ov !== 0) $display("FAIL single_overlap: got %0d want 0", ov); else n_pass++;
      n_checks++; if (us !== 0) $display("FAIL single_operand_stable: got %0d want 0", us); else n_pass++;
      tick();
      n_checks++; if (busy !== 1'b0 || resp_valid !== 2'b00)
         $display("FAIL single_back_idle: got busy %0b resp %0h want 0 0", busy, resp_valid); else n_pass++;
      n_checks++; if (resp_data !== val) $display("FAIL single_resp_hold: got %h want %h", resp_data, val); else n_pass++;
   endtask

   task automatic test_contention();
      logic [1:0]   rdy, rv;
      logic [255:0] key;
      logic [511:0] rd;
      int           ni, rc, ov, us;
      logic [1:0]   rv_seq  [5];
      logic [1:0]   exp_seq [5];
      rv_seq  = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b11};
      exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
      pulse_reset();
      tick();
      for (int i = 0; i < 5; i++) begin
         do_op(rv_seq[i], 3, {16{32'h100 + i}}, rdy, key, ni, rc, rv, rd, ov, us);
         n_checks++; if (rdy !== exp_seq[i]) $display("FAIL contention_grant_%0d: got %0h want %0h", i, rdy, exp_seq[i]); else n_pass++;
         n_checks++; if (key !== (exp_seq[i][1] ? KEY1 : KEY0)) $display("FAIL contention_key_%0d: got %h", i, key); else n_pass++;
         n_checks++; if (rv !== exp_seq[i] || rc !== 5 || ov !== 0)
            $display("FAIL contention_resp_%0d: got %0h at %0d want %0h at 5", i, rv, rc, exp_seq[i]); else n_pass++;
         tick();
      end
   endtask

   task automatic test_stale_valid();
      logic [511:0] stale, x, got;
      int           rc;
      stale = {16{32'hbad0_bad0}};
      x     = {16{32'h600d_0042}};
      got   = '0;
      rc    = -1;
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      for (int c = 1; c < 40; c++) begin
         if (c <= 2) begin
            core_data_out_valid = 1'b1;
            core_data_out       = stale;
         end else if (c <= 4) begin
            core_data_out_valid = 1'b0;
         end else begin
            core_data_out_valid = 1'b1;
            core_data_out       = x;
         end
         tick();
         if (resp_valid != 2'b00) begin
            rc  = c + 1;
            got = resp_data;
            break;
         end
      end
      core_data_out_valid = 1'b0;
      n_checks++; if (rc !== 6) $display("FAIL stale_resp_cycle: got %0d want 6", rc); else n_pass++;
      n_checks++; if (got !== x) $display("FAIL stale_resp_data: got %h want %h", got, x); else n_pass++;
      tick();
   endtask

   task automatic test_reset_mid();
      logic [1:0]   rdy, rv;
      logic [255:0] key;
      logic [511:0] rd, val;
      int           ni, rc, ov, us, seen, busy_cnt;
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      for (int c = 0; c < 20 && state_dbg != 3'd3; c++) tick();
      n_checks++; if (state_dbg !== 3'd3) $display("FAIL midreset_reach_wait_high: got %0d want 3", state_dbg); else n_pass++;
      pulse_reset();
      n_checks++; if (busy !== 1'b0 || resp_valid !== 2'b00)
         $display("FAIL midreset_abort: got busy %0b resp %0h want 0 0", busy, resp_valid); else n_pass++;
      n_checks++; if (core_key !== '0) $display("FAIL midreset_operands: got %h want 0", core_key); else n_pass++;
      seen = 0;
      busy_cnt = 0;
      core_data_out_valid = 1'b1;
      core_data_out = {16{32'hdead_dead}};
      for (int c = 0; c < 4; c++) begin
         tick();
         if (resp_valid != 2'b00) seen++;
         if (busy) busy_cnt++;
      end
      core_data_out_valid = 1'b0;
      n_checks++; if (seen !== 0 || busy_cnt !== 0)
         $display("FAIL midreset_late_valid: got %0d pulses %0d busy want 0 0", seen, busy_cnt); else n_pass++;
      tick();
      val = {16{32'h0c11_0c11}};
      do_op(2'b10, 4, val, rdy, key, ni, rc, rv, rd, ov, us);
      n_checks++; if (rdy !== 2'b10 || key !== KEY1) $display("FAIL midreset_ch1_grant: got %0h want 2", rdy); else n_pass++;
      n_checks++; if (rv !== 2'b10 || rc !== 6 || rd !== val)
         $display("FAIL midreset_ch1_resp: got %0h at %0d data %h want 2 at 6", rv, rc, rd); else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [1:0]   rdy, rv;
      logic [255:0] key;
      logic [511:0] rd;
      int           ni, rc, ov, us;
      do_op(2'b10, 2, {16{32'hb2b0_0001}}, rdy, key, ni, rc, rv, rd, ov, us);
      n_checks++; if (rv !== 2'b10 || rc !== 4) $display("FAIL b2b_first_resp: got %0h at %0d want 2 at 4", rv, rc); else n_pass++;
      req_valid = 2'b01;
      tick();
      n_checks++; if (req_ready !== 2'b00 || busy !== 1'b0)
         $display("FAIL b2b_no_accept_in_resp: got ready %0h busy %0b want 0 0", req_ready, busy); else n_pass++;
      do_op(2'b01, 2, {16{32'hb2b0_0002}}, rdy, key, ni, rc, rv, rd, ov, us);
      n_checks++; if (rdy !== 2'b01 || key !== KEY0) $display("FAIL b2b_second_grant: got %0h want 1", rdy); else n_pass++;
      n_checks++; if (rv !== 2'b01 || rd !== {16{32'hb2b0_0002}})
         $display("FAIL b2b_second_resp: got %0h data %h want 1", rv, rd); else n_pass++;
      tick();
   endtask

   task automatic test_timeout();
      logic [1:0]   rdy, rv;
      logic [255:0] key;
      logic [511:0] rd;
      int           ni, rc, ov, us;
      do_op(2'b01, 1000, '0, rdy, key, ni, rc, rv, rd, ov, us);
`ifdef CHACHA_ARB_TIMEOUT_EN
      n_checks++; if (rc !== 18 || rv !== 2'b01) $display("FAIL timeout_resp: got %0h at %0d want 1 at 18", rv, rc); else n_pass++;
      n_checks++; if (rd !== '0) $display("FAIL timeout_resp_data: got %h want 0", rd); else n_pass++;
      for (int c = 0; c < 3; c++) tick();
      n_checks++; if (timeout_err !== 1'b1) $display("FAIL timeout_err_sticky: got %0b want 1", timeout_err); else n_pass++;
      pulse_reset();
      n_checks++; if (timeout_err !== 1'b0) $display("FAIL timeout_err_clear: got %0b want 0", timeout_err); else n_pass++;
`else
      n_checks++; if (rc !== -1) $display("FAIL notimeout_resp: got cycle %0d want none", rc); else n_pass++;
      n_checks++; if (busy !== 1'b1 || state_dbg !== 3'd3)
         $display("FAIL notimeout_busy: got busy %0b state %0d want 1 3", busy, state_dbg); else n_pass++;
      n_checks++; if (timeout_err !== 1'b0) $display("FAIL notimeout_err: got %0b want 0", timeout_err); else n_pass++;
      pulse_reset();
      n_checks++; if (busy !== 1'b0) $display("FAIL notimeout_reset: got busy %0b want 0", busy); else n_pass++;
`endif
   endtask

   initial begin
      chacha_arb_reset    = 1'b1;
      req_valid           = 2'b00;
      req_key             = {KEY1, KEY0};
      req_nonce           = {64'h1111_2222_3333_4444, 64'h0};
      req_ctr             = {64'h0000_0000_0000_0007, 64'h0};
      req_data            = {{16{32'ha1a1_a1a1}}, 512'h0};
      core_data_out       = '0;
      core_data_out_valid = 1'b0;
      test_reset();
      test_single_ch0();
      test_contention();
      test_stale_valid();
      test_reset_mid();
      test_back_to_back();
      test_timeout();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
